// File: rtl/ysyx_23060124_pipe_pkg.sv
// rtl/ysyx_23060124_pipe_pkg.sv - shared types and sizes for the pipeline hazard/flush controller
package ysyx_23060124_pipe_pkg;

    localparam int PIPE_NREG  = 16;
    localparam int PIPE_AW    = 4;
    localparam int PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/ysyx_23060124_sb_cnt.sv
// rtl/ysyx_23060124_sb_cnt.sv - one saturating up/down scoreboard counter with clear and underflow flag
module ysyx_23060124_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates, inc+dec together cancel, both ends saturate
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = CNT_ZERO;
        end else if (i_inc && !i_dec) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt       = cnt_q;
    assign o_underflow = i_dec && !i_inc && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/ysyx_23060124_pipe_ctrl.sv
// rtl/ysyx_23060124_pipe_ctrl.sv - scoreboard issue gating, redirect flush and ebreak halt for IDU->EXU->WBU
module ysyx_23060124_pipe_ctrl
    import ysyx_23060124_pipe_pkg::*;
#(
    parameter int NREG  = PIPE_NREG,
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_id_valid,
    input  logic [PIPE_AW-1:0]  i_id_rs1,
    input  logic [PIPE_AW-1:0]  i_id_rs2,
    input  logic                i_id_rs1_used,
    input  logic                i_id_rs2_used,
    input  logic [PIPE_AW-1:0]  i_id_rd,
    input  logic                i_id_wen,
    input  logic                i_id_csr,
    output logic                o_id_ready,
    input  logic                i_wb_valid,
    input  logic [PIPE_AW-1:0]  i_wb_rd,
    input  logic                i_wb_wen,
    input  logic                i_wb_csr,
    input  logic                i_wb_redirect,
    input  logic                i_wb_ebreak,
    input  logic [31:0]         i_wb_pc_next,
    output logic                o_flush,
    output logic                o_redirect_valid,
    output logic [31:0]         o_redirect_pc,
    output logic                o_halted,
    output logic [NREG-1:0]     o_busy_vec,
    output logic                o_sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    pipe_state_e state_q, state_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        csr_pend_q, csr_pend_d;
    logic        sb_err_q, sb_err_d;

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic [NREG-1:0]  uf_vec;

    logic in_run;
    logic wb_take;
    logic redirect_det;
    logic ebreak_det;
    logic issue;
    logic sb_clr;
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic csr_block;

    // Register 0 is hardwired and never tracked
    assign cnt[0]     = CNT_ZERO;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;
    assign uf_vec[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        assign inc_vec[r] = issue && i_id_wen && (i_id_rd == PIPE_AW'(r));
        assign dec_vec[r] = wb_take && i_wb_wen && (i_wb_rd == PIPE_AW'(r));

        ysyx_23060124_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock       (clock),
            .reset       (reset),
            .i_inc       (inc_vec[r]),
            .i_dec       (dec_vec[r]),
            .i_clr       (sb_clr),
            .o_cnt       (cnt[r]),
            .o_underflow (uf_vec[r])
        );
    end

    // Issue gating from registered scoreboard state only; retires are not bypassed
    always_comb begin
        in_run     = (state_q == ST_RUN);
        rs1_busy   = i_id_rs1_used && (cnt[i_id_rs1] != CNT_ZERO);
        rs2_busy   = i_id_rs2_used && (cnt[i_id_rs2] != CNT_ZERO);
        rd_full    = i_id_wen && (cnt[i_id_rd] == CNT_MAX);
        csr_block  = i_id_csr && csr_pend_q;
        o_id_ready = in_run && !rs1_busy && !rs2_busy && !rd_full && !csr_block;
        issue      = i_id_valid && o_id_ready;
        // Retire inputs are only meaningful while running; in FLUSH the pipe is empty
        wb_take      = in_run && i_wb_valid;
        ebreak_det   = wb_take && i_wb_ebreak;
        redirect_det = wb_take && i_wb_redirect && !i_wb_ebreak;
        // The redirect-detect cycle already wipes the scoreboard, dropping any same-cycle issue
        sb_clr       = redirect_det || (state_q == ST_FLUSH);
    end

    // Next-state and registered-output computation for the run/flush/halt controller
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (ebreak_det) begin
                    state_d = ST_HALT;
                end else if (redirect_det) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = i_wb_pc_next;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
        flush_d  = (state_d == ST_FLUSH);
        halted_d = (state_d == ST_HALT);

        csr_pend_d = csr_pend_q;
        if (sb_clr) begin
            csr_pend_d = 1'b0;
        end else if (issue && i_id_csr) begin
            csr_pend_d = 1'b1;
        end else if (wb_take && i_wb_csr) begin
            csr_pend_d = 1'b0;
        end

        sb_err_d = sb_err_q || (|uf_vec);
    end

    // Controller state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
            redirect_pc_q <= 32'h0;
            csr_pend_q    <= 1'b0;
            sb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
            redirect_pc_q <= redirect_pc_d;
            csr_pend_q    <= csr_pend_d;
            sb_err_q      <= sb_err_d;
        end
    end

    // Busy view of the scoreboard for debug and forwarding decisions upstream
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            o_busy_vec[r] = (cnt[r] != CNT_ZERO);
        end
    end

    assign o_flush          = flush_q;
    assign o_redirect_valid = flush_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_halted         = halted_q;
    assign o_sb_err         = sb_err_q;

endmodule

// File: tb/tb_ysyx_23060124_pipe_ctrl.sv
// tb/tb_ysyx_23060124_pipe_ctrl.sv - randomized and directed checks of the pipeline controller against a behavioural model
module tb_ysyx_23060124_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_id_valid;
    logic [3:0]  i_id_rs1, i_id_rs2, i_id_rd;
    logic        i_id_rs1_used, i_id_rs2_used, i_id_wen, i_id_csr;
    logic        o_id_ready;
    logic        i_wb_valid;
    logic [3:0]  i_wb_rd;
    logic        i_wb_wen, i_wb_csr, i_wb_redirect, i_wb_ebreak;
    logic [31:0] i_wb_pc_next;
    logic        o_flush, o_redirect_valid, o_halted, o_sb_err;
    logic [31:0] o_redirect_pc;
    logic [15:0] o_busy_vec;

    always #5 clock = ~clock;

    ysyx_23060124_pipe_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .i_id_valid       (i_id_valid),
        .i_id_rs1         (i_id_rs1),
        .i_id_rs2         (i_id_rs2),
        .i_id_rs1_used    (i_id_rs1_used),
        .i_id_rs2_used    (i_id_rs2_used),
        .i_id_rd          (i_id_rd),
        .i_id_wen         (i_id_wen),
        .i_id_csr         (i_id_csr),
        .o_id_ready       (o_id_ready),
        .i_wb_valid       (i_wb_valid),
        .i_wb_rd          (i_wb_rd),
        .i_wb_wen         (i_wb_wen),
        .i_wb_csr         (i_wb_csr),
        .i_wb_redirect    (i_wb_redirect),
        .i_wb_ebreak      (i_wb_ebreak),
        .i_wb_pc_next     (i_wb_pc_next),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_halted         (o_halted),
        .o_busy_vec       (o_busy_vec),
        .o_sb_err         (o_sb_err)
    );

    // Behavioural model: pending-write counts as integers, plus the controller mode
    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;
    int          m_cnt [16];
    bit          m_csr, m_err;
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_ready, m_fire, m_clear;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [3:0] rd; logic wen; logic csr; } ent_t;
    ent_t inflight[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        bit r;
        r = (m_mode == M_RUN);
        if (i_id_rs1_used && m_cnt[i_id_rs1] > 0) r = 0;
        if (i_id_rs2_used && m_cnt[i_id_rs2] > 0) r = 0;
        if (i_id_wen && i_id_rd != 0 && m_cnt[i_id_rd] >= 3) r = 0;
        if (i_id_csr && m_csr) r = 0;
        return r;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] > 0);
        return b;
    endfunction

    // Compare every observable output with the model
    task automatic check_all();
        m_ready = model_ready();
        chk("ready", 32'(o_id_ready), 32'(m_ready));
        chk("flush", 32'(o_flush), 32'(m_mode == M_FLUSH));
        chk("redirect_valid", 32'(o_redirect_valid), 32'(m_mode == M_FLUSH));
        if (m_mode == M_FLUSH) chk("redirect_pc", o_redirect_pc, m_pc);
        chk("halted", 32'(o_halted), 32'(m_mode == M_HALT));
        chk("busy_vec", 32'(o_busy_vec), 32'(model_busy()));
        chk("sb_err", 32'(o_sb_err), 32'(m_err));
    endtask

    // Advance the model by one clock from the inputs currently applied
    task automatic model_step();
        m_fire  = 0;
        m_clear = 0;
        if (reset) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_csr = 0; m_err = 0; m_mode = M_RUN; m_pc = 32'h0;
            return;
        end
        case (m_mode)
            M_RUN: begin
                int delta [16];
                bit wb_ok;
                foreach (delta[r]) delta[r] = 0;
                wb_ok  = i_wb_valid;
                m_fire = i_id_valid && m_ready;
                if (m_fire && i_id_wen && i_id_rd != 0) delta[i_id_rd] += 1;
                if (wb_ok && i_wb_wen && i_wb_rd != 0) delta[i_wb_rd] -= 1;
                for (int r = 1; r < 16; r++) begin
                    int v;
                    v = m_cnt[r] + delta[r];
                    if (v < 0) begin m_err = 1; v = 0; end
                    if (v > 3) v = 3;
                    m_cnt[r] = v;
                end
                if (m_fire && i_id_csr) m_csr = 1;
                else if (wb_ok && i_wb_csr) m_csr = 0;
                if (wb_ok && i_wb_ebreak) begin
                    m_mode = M_HALT;
                end else if (wb_ok && i_wb_redirect) begin
                    m_clear = 1;
                    foreach (m_cnt[r]) m_cnt[r] = 0;
                    m_csr  = 0;
                    m_pc   = i_wb_pc_next;
                    m_mode = M_FLUSH;
                end
            end
            M_FLUSH: begin
                foreach (m_cnt[r]) m_cnt[r] = 0;
                m_csr  = 0;
                m_mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    task automatic cycle();
        #1;
        check_all();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_rd = 0;
        i_id_rs1_used = 0; i_id_rs2_used = 0; i_id_wen = 0; i_id_csr = 0;
        i_wb_valid = 0; i_wb_rd = 0; i_wb_wen = 0; i_wb_csr = 0;
        i_wb_redirect = 0; i_wb_ebreak = 0; i_wb_pc_next = 32'h0;
    endtask

    task automatic set_id(logic [3:0] rs1, logic u1, logic [3:0] rs2, logic u2,
                          logic [3:0] rd, logic wen, logic csr);
        i_id_valid = 1; i_id_rs1 = rs1; i_id_rs1_used = u1; i_id_rs2 = rs2;
        i_id_rs2_used = u2; i_id_rd = rd; i_id_wen = wen; i_id_csr = csr;
    endtask

    task automatic set_wb(logic [3:0] rd, logic wen, logic csr, logic redir,
                          logic ebrk, logic [31:0] pc);
        i_wb_valid = 1; i_wb_rd = rd; i_wb_wen = wen; i_wb_csr = csr;
        i_wb_redirect = redir; i_wb_ebreak = ebrk; i_wb_pc_next = pc;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cycle();
        reset = 0;
        inflight.delete();
    endtask

    initial begin
        int halt_cycles;
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_csr = 0; m_err = 0; m_mode = M_RUN; m_pc = 32'h0;
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;

        // Reset state
        #1;
        chk("rst_ready", 32'(o_id_ready), 32'd1);
        chk("rst_busy", 32'(o_busy_vec), 32'd0);
        chk("rst_pc", o_redirect_pc, 32'h0);

        // x5 write then dependent read
        set_id(0, 0, 0, 0, 4'd5, 1, 0);
        cycle();
        set_id(4'd5, 1, 0, 0, 0, 0, 0);
        #1; chk("x5_stall", 32'(o_id_ready), 32'd0);
        chk("x5_busy", 32'(o_busy_vec[5]), 32'd1);
        cycle();
        set_wb(4'd5, 1, 0, 0, 0, 0);
        #1; chk("x5_no_bypass", 32'(o_id_ready), 32'd0);
        cycle();
        i_wb_valid = 0;
        #1; chk("x5_ready_after", 32'(o_id_ready), 32'd1);
        cycle();
        do_reset();

        // three x7 writes saturate, simultaneous issue/retire keeps the count
        set_id(0, 0, 0, 0, 4'd7, 1, 0);
        repeat (3) cycle();
        #1; chk("x7_full", 32'(o_id_ready), 32'd0);
        set_wb(4'd7, 1, 0, 0, 0, 0);
        cycle();
        #1; chk("x7_after_retire", 32'(o_id_ready), 32'd1);
        cycle();
        #1; chk("x7_cnt_two", 32'(o_id_ready), 32'd1);
        i_wb_valid = 0;
        cycle();
        #1; chk("x7_full_again", 32'(o_id_ready), 32'd0);
        do_reset();

        // x0 never stalls
        set_id(0, 1, 0, 1, 0, 1, 0);
        repeat (3) cycle();
        #1; chk("x0_ready", 32'(o_id_ready), 32'd1);
        chk("x0_busy", 32'(o_busy_vec[0]), 32'd0);

        // jal redirect with x3/x9 busy, same-cycle issue dropped
        set_id(0, 0, 0, 0, 4'd3, 1, 0); cycle();
        set_id(0, 0, 0, 0, 4'd9, 1, 0); cycle();
        set_id(0, 0, 0, 0, 4'd1, 1, 0);
        set_wb(4'd0, 0, 0, 1, 0, 32'h8000_0040);
        cycle();
        idle();
        #1; chk("jal_flush", 32'(o_flush), 32'd1);
        chk("jal_pc", o_redirect_pc, 32'h8000_0040);
        chk("jal_busy", 32'(o_busy_vec), 32'd0);
        chk("jal_ready", 32'(o_id_ready), 32'd0);
        cycle();
        #1; chk("jal_flush_off", 32'(o_flush), 32'd0);
        chk("jal_ready_back", 32'(o_id_ready), 32'd1);

        // CSR serialisation
        set_id(0, 0, 0, 0, 0, 0, 1); cycle();
        #1; chk("csr_stall", 32'(o_id_ready), 32'd0);
        set_wb(0, 0, 1, 0, 0, 0);
        cycle();
        i_wb_valid = 0;
        #1; chk("csr_ready", 32'(o_id_ready), 32'd1);
        cycle();
        idle();

        // ebreak beats a simultaneous redirect
        set_wb(0, 0, 0, 1, 1, 32'h1234);
        cycle();
        idle();
        #1; chk("ebrk_halted", 32'(o_halted), 32'd1);
        chk("ebrk_no_flush", 32'(o_flush), 32'd0);
        repeat (3) cycle();
        #1; chk("ebrk_still", 32'(o_halted), 32'd1);
        do_reset();
        #1; chk("ebrk_reset", 32'(o_halted), 32'd0);

        // underflow is sticky until reset
        set_wb(4'd4, 1, 0, 0, 0, 0);
        cycle();
        idle();
        cycle();
        #1; chk("sb_err_set", 32'(o_sb_err), 32'd1);
        do_reset();
        #1; chk("sb_err_clr", 32'(o_sb_err), 32'd0);

        // reset asserted during FLUSH
        set_id(0, 0, 0, 0, 4'd2, 1, 0); cycle();
        idle();
        set_wb(0, 0, 0, 1, 0, 32'hdead_beef);
        cycle();
        idle();
        reset = 1;
        cycle();
        reset = 0;
        #1; chk("rf_flush", 32'(o_flush), 32'd0);
        chk("rf_rvalid", 32'(o_redirect_valid), 32'd0);
        chk("rf_pc", o_redirect_pc, 32'h0);
        chk("rf_ready", 32'(o_id_ready), 32'd1);

        // randomized traffic
        inflight.delete();
        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            ent_t e;
            bit   retiring;
            idle();
            retiring = 0;
            if ($urandom_range(0, 9) < 7) begin
                e.rd  = 4'($urandom_range(0, 7));
                e.wen = ($urandom_range(0, 9) < 7);
                e.csr = ($urandom_range(0, 9) < 1);
                set_id(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       e.rd, e.wen, e.csr);
            end else begin
                e.rd = 0; e.wen = 0; e.csr = 0;
            end
            if (m_mode == M_RUN && inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                retiring = 1;
                set_wb(inflight[0].rd, inflight[0].wen, inflight[0].csr,
                       ($urandom_range(0, 11) == 0), ($urandom_range(0, 199) == 0),
                       $urandom());
            end
            reset = ($urandom_range(0, 399) == 0);
            cycle();
            if (reset || m_clear) begin
                inflight.delete();
            end else begin
                if (retiring) void'(inflight.pop_front());
                if (m_fire) inflight.push_back(e);
            end
            reset = 0;
            if (m_mode == M_HALT) begin
                halt_cycles++;
                if (halt_cycles > 4) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_pipe_ctrl.md
# ysyx_23060124_pipe_ctrl

Pipeline hazard and flush controller for the IDU→EXU→WBU pipeline. It keeps a per-register write scoreboard and holds issue from the IDU while any source or CSR dependency is outstanding. On a control-flow redirect retiring at the EXU/WBU register stage, it kills younger instructions and drives the fetch redirect. It halts the pipeline on ebreak.

## Interface
Parameters:
- NREG, 16: number of GPRs (RV32E).
- CNT_W, 2: width of each scoreboard counter; at most 3 in-flight writes per register.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_id_valid  in  1  IDU holds a decoded instruction.
- i_id_rs1 / i_id_rs2  in  4  source register addresses.
- i_id_rs1_used / i_id_rs2_used  in  1  the matching source is actually read.
- i_id_rd  in  4  destination register.
- i_id_wen  in  1  instruction writes a GPR.
- i_id_csr  in  1  instruction accesses a CSR (Zicsr, mret, ecall).
- o_id_ready  out  1  issue permitted; issue fires on i_id_valid && o_id_ready.
- i_wb_valid  in  1  an instruction retires from the EXU/WBU register this cycle.
- i_wb_rd  in  4  its destination register.
- i_wb_wen / i_wb_csr  in  1  its GPR write and CSR access flags.
- i_wb_redirect  in  1  taken branch, jal, jalr, mret or ecall.
- i_wb_ebreak  in  1  retiring instruction is ebreak.
- i_wb_pc_next  in  32  redirect target.
- o_flush  out  1  kill IFU/IDU/EXU contents and clear EXU/WBU register valid.
- o_redirect_valid  out  1  fetch redirect strobe.
- o_redirect_pc  out  32  fetch redirect target.
- o_halted  out  1  pipeline stopped by ebreak.
- o_busy_vec  out  NREG  bit r set when cnt[r] != 0.
- o_sb_err  out  1  sticky: a retire decremented a zero counter.

## Operation
- Scoreboard: cnt[r] for r = 1..15; r = 0 is never tracked and always reads 0.
- Increment cnt[rd] on issue when i_id_wen && rd != 0.
- Decrement cnt[rd] on i_wb_valid && i_wb_wen && rd != 0.
- Increment and decrement of the same register in the same cycle: net unchanged.
- Decrement at 0: counter stays 0 and o_sb_err sets. o_sb_err is cleared only by reset.
- csr_pend flag: set on issue with i_id_csr; cleared on i_wb_valid && i_wb_csr. Set and clear in the same cycle: set wins.
- o_id_ready = (state == RUN) && none of the following holds:
  - a used source has cnt != 0;
  - i_id_wen && cnt[rd] == max;
  - i_id_csr && csr_pend.
- o_id_ready uses registered state only; a same-cycle retire is not bypassed.
- States:
  - RUN: normal issue.
  - i_wb_valid && i_wb_redirect → FLUSH.
  - i_wb_valid && i_wb_ebreak → HALT. ebreak wins over a simultaneous redirect.
  - FLUSH: lasts exactly one cycle; o_flush = o_redirect_valid = 1; all counters and csr_pend clear; then → RUN.
  - HALT: o_halted = 1; o_id_ready = 0; absorbing until reset.
- A redirect in FLUSH cannot occur because the pipe is empty; any such i_wb_* input is ignored.
- An issue in the same cycle as the redirect-detect is dropped: the clear wins.

## Timing
- Reset values: state RUN, all cnt 0, csr_pend 0, o_flush 0, o_redirect_valid 0, o_redirect_pc 0, o_halted 0, o_busy_vec 0, o_sb_err 0.
- o_id_ready is 1 in the first cycle after reset.
- Redirect retire at cycle t: o_flush, o_redirect_valid and o_redirect_pc (= i_wb_pc_next captured at t) are valid at t+1 for one cycle. o_id_ready = 0 at t+1; earliest new issue at t+2.
- Scoreboard update at edge t makes o_busy_vec and o_id_ready reflect it from t+1.
- ebreak retire at t: o_halted = 1 from t+1.
- Reset asserted mid-FLUSH or in HALT: next cycle is the full reset state; no residual flush pulse.

## Structure
- Shared package ysyx_23060124_pipe_pkg holds:
  - the state enum {RUN, FLUSH, HALT};
  - NREG and the register-address width (4);
  - CNT_W.
- Sub-module ysyx_23060124_sb_cnt: one saturating up/down counter with inc, dec, clr and underflow flag, instantiated for registers 1..15.
- The top level holds the FSM, csr_pend, the ready logic and the redirect registers.

## Test plan
- Issue x5 write, then dependent read of x5: o_id_ready = 0 until the x5 retire at cycle t; ready = 1 at t+1.
- Three writes to x7 in flight: a fourth x7 write stalls; it issues the cycle after one x7 retire. A simultaneous issue and retire of x7 keeps cnt = 2.
- Write x0 and read x0: never stalls; o_busy_vec[0] stays 0.
- jal retires with pc_next = 0x8000_0040 while x3 and x9 are busy: next cycle o_flush = 1, o_redirect_pc = 0x8000_0040, o_busy_vec = 0; an issue attempted in the detect cycle is dropped.
- CSR access in flight: a second CSR access stalls until i_wb_csr retires. Simultaneous ebreak + redirect → HALT, no flush; o_halted stays 1 until reset.
- Retire of x4 with cnt[4] = 0 → o_sb_err = 1. Reset mid-FLUSH → all outputs at reset values the next cycle.
